// File: rtl/act_pwl_pkg.sv
// Shared types and default dimensions for the piecewise-linear activation unit.
// Coefficients are signed fixed point; a LUT entry is one {slope, offset} pair.
package act_pwl_pkg;

    localparam int ACT_LANES      = 4;
    localparam int ACT_Q_INT      = 4;
    localparam int ACT_Q_FRAC     = 12;
    localparam int ACT_SEG_DEPTH  = 6;
    localparam int ACT_FUNC_SEL_W = 2;

    localparam int ACT_A_INT  = 4;
    localparam int ACT_A_FRAC = 12;
    localparam int ACT_B_INT  = 4;
    localparam int ACT_B_FRAC = 12;

    localparam int ACT_Q_SIZE    = ACT_Q_INT + ACT_Q_FRAC;
    localparam int ACT_COEF_SIZE = ACT_A_INT + ACT_A_FRAC;

    typedef logic [ACT_FUNC_SEL_W-1:0] act_func_t;

    typedef struct packed {
        logic signed [ACT_COEF_SIZE-1:0] a;
        logic signed [ACT_COEF_SIZE-1:0] b;
    } act_coef_t;

endpackage

// File: rtl/act_pwl_lane.sv
// One lane of the activation datapath: S2 multiply, S3 offset add, round and saturate.
// All state advances only on adv so a stalled beat holds its value.
module act_pwl_lane #(
    parameter int Q_SIZE    = 16,
    parameter int Q_FRAC    = 12,
    parameter int COEF_SIZE = 16,
    parameter int COEF_FRAC = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        adv,
    input  logic                        s2_valid,
    input  logic signed [Q_SIZE-1:0]    x,
    input  logic signed [COEF_SIZE-1:0] a,
    input  logic signed [COEF_SIZE-1:0] b,
    output logic        [Q_SIZE-1:0]    y,
    output logic                        clip
);

    localparam int PW = Q_SIZE + COEF_SIZE;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (COEF_FRAC - 1);

    logic signed [PW-1:0]        x_ext;
    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        p2;
    logic signed [COEF_SIZE-1:0] b2;
    logic signed [SW-1:0]        p_ext;
    logic signed [SW-1:0]        b_al;
    logic signed [SW-1:0]        sum;
    logic signed [SW-1:0]        rnd;
    logic signed [SW-1:0]        shf;
    logic                        fits;
    logic        [Q_SIZE-1:0]    y_next;

    always_comb begin
        x_ext = {{(PW-Q_SIZE){x[Q_SIZE-1]}}, x};
        a_ext = {{(PW-COEF_SIZE){a[COEF_SIZE-1]}}, a};
        p_ext = {{(SW-PW){p2[PW-1]}}, p2};
        // Offset is scaled up by Q_FRAC so it lines up with the product's binary point.
        b_al  = {{(SW-COEF_SIZE-Q_FRAC){b2[COEF_SIZE-1]}}, b2, {Q_FRAC{1'b0}}};
        sum   = p_ext + b_al;
        rnd   = sum + HALF;
        shf   = rnd >>> COEF_FRAC;
        fits  = (&shf[SW-1:Q_SIZE-1]) || !(|shf[SW-1:Q_SIZE-1]);
        if (fits) begin
            y_next = shf[Q_SIZE-1:0];
        end else if (shf[SW-1]) begin
            y_next = {1'b1, {(Q_SIZE-1){1'b0}}};
        end else begin
            y_next = {1'b0, {(Q_SIZE-1){1'b1}}};
        end
    end

    assign clip = adv && s2_valid && !fits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p2 <= '0;
            b2 <= '0;
            y  <= '0;
        end else if (adv) begin
            p2 <= x_ext * a_ext;
            b2 <= b;
            y  <= y_next;
        end
    end

endmodule

// File: rtl/act_pwl_unit.sv
// Multi-lane piecewise-linear activation: y = sat(A[f][seg]*x + B[f][seg]) per lane,
// three-stage pipeline with a runtime-loadable coefficient table shared by all lanes.
module act_pwl_unit
    import act_pwl_pkg::*;
#(
    parameter int LANES      = ACT_LANES,
    parameter int Q_INT      = ACT_Q_INT,
    parameter int Q_FRAC     = ACT_Q_FRAC,
    parameter int SEG_DEPTH  = ACT_SEG_DEPTH,
    parameter int FUNC_SEL_W = ACT_FUNC_SEL_W,
    parameter int COEF_INT   = ACT_A_INT,
    parameter int COEF_FRAC  = ACT_A_FRAC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FUNC_SEL_W-1:0]       in_func,
    input  logic [LANES*(Q_INT+Q_FRAC)-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*(Q_INT+Q_FRAC)-1:0] out_data,
    input  logic                        cfg_we,
    input  logic [FUNC_SEL_W-1:0]       cfg_func,
    input  logic [SEG_DEPTH-1:0]        cfg_seg,
    input  logic [COEF_INT+COEF_FRAC-1:0] cfg_a,
    input  logic [COEF_INT+COEF_FRAC-1:0] cfg_b,
    output logic [LANES-1:0]            sat_flag,
    input  logic                        sat_clr
);

    localparam int Q_SIZE    = Q_INT + Q_FRAC;
    localparam int COEF_SIZE = COEF_INT + COEF_FRAC;
    localparam int IDX_W     = FUNC_SEL_W + SEG_DEPTH;
    localparam int N_ENTRIES = 2 ** IDX_W;
    localparam logic [COEF_SIZE-1:0] COEF_ONE = COEF_SIZE'(1) << COEF_FRAC;

    logic [COEF_SIZE-1:0] lut_a [N_ENTRIES];
    logic [COEF_SIZE-1:0] lut_b [N_ENTRIES];

    logic                        adv;
    logic                        v1, v2, v3;
    logic        [Q_SIZE-1:0]    in_lane [LANES];
    logic        [IDX_W-1:0]     rd_idx  [LANES];
    logic signed [Q_SIZE-1:0]    x1      [LANES];
    logic signed [COEF_SIZE-1:0] a1      [LANES];
    logic signed [COEF_SIZE-1:0] b1      [LANES];
    logic        [Q_SIZE-1:0]    lane_y  [LANES];
    logic        [LANES-1:0]     clip_vec;

    // Handshake: a beat transfers on in_valid && in_ready; the output is held while
    // out_valid && !out_ready. The whole pipe moves together, so in_ready is simply
    // "S3 is empty or being drained this cycle".
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // Segment index is the offset-binary top bits of x, prefixed by the function bank.
    for (genvar g = 0; g < LANES; g++) begin : g_idx
        assign in_lane[g] = in_data[g*Q_SIZE +: Q_SIZE];
        assign rd_idx[g]  = {in_func, ~in_lane[g][Q_SIZE-1],
                             in_lane[g][Q_SIZE-2 -: SEG_DEPTH-1]};
    end

    // Writes ignore stall; a same-cycle S1 read of the entry sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                lut_a[e] <= COEF_ONE;
                lut_b[e] <= '0;
            end
        end else if (cfg_we) begin
            lut_a[{cfg_func, cfg_seg}] <= cfg_a;
            lut_b[{cfg_func, cfg_seg}] <= cfg_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                x1[i] <= '0;
                a1[i] <= '0;
                b1[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < LANES; i++) begin
                x1[i] <= in_lane[i];
                a1[i] <= lut_a[rd_idx[i]];
                b1[i] <= lut_b[rd_idx[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            sat_flag <= '0;
        end else begin
            if (adv) begin
                v1 <= in_valid;
                v2 <= v1;
                v3 <= v2;
            end
            sat_flag <= (sat_flag & {LANES{~sat_clr}}) | clip_vec;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_pwl_lane #(
            .Q_SIZE    (Q_SIZE),
            .Q_FRAC    (Q_FRAC),
            .COEF_SIZE (COEF_SIZE),
            .COEF_FRAC (COEF_FRAC)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .s2_valid (v2),
            .x        (x1[g]),
            .a        (a1[g]),
            .b        (b1[g]),
            .y        (lane_y[g]),
            .clip     (clip_vec[g])
        );
        assign out_data[g*Q_SIZE +: Q_SIZE] = lane_y[g];
    end

endmodule

// File: tb/tb_act_pwl_unit.sv
// Bench for act_pwl_unit: model LUT plus arithmetic reference feeding an expected queue,
// a negedge monitor that pops and compares, and directed/random phases.
module tb_act_pwl_unit;
    import act_pwl_pkg::*;

    localparam int LANES = 4;
    localparam int QS    = 16;
    localparam int W     = LANES * QS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_func = '0;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_func = '0;
    logic [5:0]       cfg_seg = '0;
    logic [15:0]      cfg_a = '0;
    logic [15:0]      cfg_b = '0;
    logic [LANES-1:0] sat_flag;
    logic             sat_clr = 1'b0;

    logic [W-1:0]     exp_q[$];
    logic [LANES-1:0] exp_sat = '0;
    logic [15:0]      ma [4][64];
    logic [15:0]      mb [4][64];
    int               n_cmp = 0;
    int               n_err = 0;
    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_data = '0;
    bit               bp_on = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    act_pwl_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_func   (in_func),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_func  (cfg_func),
        .cfg_seg   (cfg_seg),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model
    task automatic model_reset();
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 64; s++) begin
                ma[f][s] = 16'h1000;
                mb[f][s] = 16'h0000;
            end
    endtask

    function automatic logic [15:0] model_lane(input logic [15:0] x, input logic [15:0] a,
                                               input logic [15:0] b, output logic clip);
        longint s;
        longint r;
        logic [63:0] rv;
        s = longint'($signed(x)) * longint'($signed(a)) + longint'($signed(b)) * 4096;
        r = (s + 2048) >>> 12;
        clip = 1'b1;
        if (r > 32767)       return 16'h7FFF;
        else if (r < -32768) return 16'h8000;
        clip = 1'b0;
        rv = r;
        return rv[15:0];
    endfunction

    task automatic predict(input logic [1:0] f, input logic [W-1:0] d,
                           output logic [W-1:0] y, output logic [LANES-1:0] c);
        logic [15:0] x;
        int seg;
        logic cl;
        y = '0;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            x = d[i*QS +: QS];
            seg = (int'($signed(x)) + 32768) >> 10;
            y[i*QS +: QS] = model_lane(x, ma[f][seg], mb[f][seg], cl);
            c[i] = cl;
        end
    endtask

    // driver tasks: every task starts and ends 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [1:0] f, input logic [W-1:0] d, input bit push);
        logic [W-1:0] y;
        logic [LANES-1:0] c;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_func  = f;
        in_data  = d;
        predict(f, d, y, c);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check_eq("accept_timeout", 1, 0);
                break;
            end
        end
        if (push) begin
            exp_q.push_back(y);
            exp_sat = exp_sat | c;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] f, input logic [5:0] s,
                             input logic [15:0] a, input logic [15:0] b);
        cfg_we   = 1'b1;
        cfg_func = f;
        cfg_seg  = s;
        cfg_a    = a;
        cfg_b    = b;
        tick(1);
        cfg_we   = 1'b0;
        ma[f][s] = a;
        mb[f][s] = b;
    endtask

    task automatic pulse_sat_clr();
        sat_clr = 1'b1;
        tick(1);
        sat_clr = 1'b0;
        exp_sat = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 0);
        tick(2);
    endtask

    // scoreboard / protocol monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            check_eq("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
                check_eq("stall_data", out_data, prev_data);
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_out", out_data, 64'hDEAD);
                else check_eq("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin : main
        logic [W-1:0] d;
        int n;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        check_eq("rst_out_valid", {63'd0, out_valid}, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_sat_flag", {60'd0, sat_flag}, 0);
        check_eq("rst_in_ready", {63'd0, in_ready}, 1);

        // identity after reset, with latency measurement
        d = {16'h7FFF, 16'h0000, 16'hE800, 16'h1800};
        send_beat(2'd0, d, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check_eq("id_latency", 64'(n), 3);
        check_eq("id_data", out_data, d);
        @(posedge clk);
        #1;
        wait_drain(50);
        check_eq("id_sat_flag", {60'd0, sat_flag}, 0);

        // bank 1: y = 2x + 1
        for (int s = 0; s < 64; s++) cfg_write(2'd1, 6'(s), 16'h2000, 16'h1000);
        send_beat(2'd1, {16'hF000, 16'h1000, 16'hF000, 16'h1000}, 1'b1);
        for (int k = 0; k < 8; k++)
            send_beat(2'd1, {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                             16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))}, 1'b1);
        wait_drain(100);
        check_eq("b1_sat_flag", {60'd0, sat_flag}, {60'd0, exp_sat});

        // bank 2: constant per segment
        for (int s = 0; s < 64; s++) cfg_write(2'd2, 6'(s), 16'h0000, 16'(s << 4));
        send_beat(2'd2, {16'h0000, 16'h7FFF, 16'h0000, 16'h8000}, 1'b1);
        wait_drain(50);

        // saturation and sticky flags
        pulse_sat_clr();
        check_eq("clr_sat_flag", {60'd0, sat_flag}, 0);
        cfg_write(2'd3, 6'd63, 16'h7FFF, 16'h7FFF);
        cfg_write(2'd3, 6'd0, 16'h7FFF, 16'h8000);
        send_beat(2'd3, {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b1);
        wait_drain(50);
        check_eq("sat_flag_set", {60'd0, sat_flag}, {60'd0, exp_sat});
        pulse_sat_clr();
        tick(1);
        check_eq("sat_flag_clr", {60'd0, sat_flag}, 0);

        // backpressure with random out_ready
        bp_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    for (int i = 0; i < LANES; i++) d[i*QS +: QS] = 16'(k * 256 + i * 64);
                    send_beat(2'(k % 2), d, 1'b1);
                end
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk);
                    #1;
                    if (bp_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(200);

        // write collision: the beat read in the write cycle sees the old entry
        cfg_we   = 1'b1;
        cfg_func = 2'd0;
        cfg_seg  = 6'd36;
        cfg_a    = 16'h3000;
        cfg_b    = 16'h0000;
        send_beat(2'd0, {4{16'h1000}}, 1'b1);
        cfg_we = 1'b0;
        ma[0][36] = 16'h3000;
        send_beat(2'd0, {4{16'h1000}}, 1'b1);
        wait_drain(50);

        // reset with three beats in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_beat(2'd1, {4{16'(k * 512 + 256)}}, 1'b0);
        rst_n = 1'b0;
        tick(2);
        check_eq("mid_rst_out_valid", {63'd0, out_valid}, 0);
        check_eq("mid_rst_sat_flag", {60'd0, sat_flag}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        model_reset();
        exp_sat = '0;
        tick(8);
        for (int k = 0; k < 8; k++)
            send_beat(2'($urandom_range(0, 3)),
                      {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))}, 1'b1);
        wait_drain(100);
        check_eq("final_sat_flag", {60'd0, sat_flag}, {60'd0, exp_sat});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/act_pwl_unit.md
Name: act_pwl_unit

Overview:
- Multi-lane, pipelined, piecewise-linear activation engine for the neural-unit array. Computes y = sat(A[f][seg]*x + B[f][seg]) per lane in fixed point.
- Sits between the NU accumulators and XY memory write-back.
- Successor to the fixed-size activation LUT: lane count, Q format, segment count and function count are parametrised; LUT is runtime-loadable and supports selectable functions.

Parameters:
- LANES, 4, parallel lanes (equals NU_COUNT).
- Q_INT, 4, integer bits of data, sign included.
- Q_FRAC, 12, fractional bits of data; Q_SIZE = Q_INT + Q_FRAC.
- SEG_DEPTH, 6, log2 of segments per function.
- FUNC_SEL_W, 2, function-select width; N_FUNCS = 2**FUNC_SEL_W.
- COEF_INT, 4, integer bits of A and B.
- COEF_FRAC, 12, fractional bits of A and B; COEF_SIZE = COEF_INT + COEF_FRAC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat.
- in_func  in  FUNC_SEL_W  function bank for this beat.
- in_data  in  LANES*Q_SIZE  signed lane inputs; lane i at [i*Q_SIZE +: Q_SIZE].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*Q_SIZE  signed saturated results.
- cfg_we  in  1  coefficient write strobe.
- cfg_func  in  FUNC_SEL_W  bank to write.
- cfg_seg  in  SEG_DEPTH  segment to write.
- cfg_a  in  COEF_SIZE  slope, signed.
- cfg_b  in  COEF_SIZE  offset, signed.
- sat_flag  out  LANES  sticky per-lane saturation flag.
- sat_clr  in  1  clears sat_flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, all stage valids and sat_flag go to 0; out_data goes to 0.
  - Every LUT entry is loaded with A = 1.0 (1<<COEF_FRAC) and B = 0, i.e. identity.
  - Reset mid-stream discards all in-flight beats; no output is produced for them.
- Pipeline: 3 stages, latency 3 cycles from accept to out_valid when unstalled; throughput 1 beat/cycle.
  - S1: segment index plus registered LUT read of A and B per lane. Each lane has its own read port over the shared register array.
  - S2: signed product P = x*A, width Q_SIZE+COEF_SIZE.
  - S3: add, round, saturate; result registered to out_data.
- Segment index: seg = {~x[MSB], x[MSB-1 -: SEG_DEPTH-1]}, offset-binary over the full input range.
  - x = 0x8000 gives seg 0; x = 0x0000 gives seg 32; x = 0x7FFF gives seg 63.
- Arithmetic:
  - B is sign-extended and shifted left by Q_FRAC to align with P.
  - S = P + B_aligned, carried at width +1 bit.
  - Round half-up: add 1<<(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - Saturate to Q_SIZE signed: 0x7FFF high, 0x8000 low.
  - Whenever a lane clips on a valid beat, that lane's sat_flag bit is set.
- Handshake:
  - adv = !v3 || out_ready, where v3 is the S3 valid; in_ready = adv.
  - The whole pipe advances only when adv is 1; a transfer occurs when in_valid && in_ready.
  - out_data and out_valid stay stable while out_valid && !out_ready; no beat is lost or duplicated.
  - in_func travels with its beat through S1.
- Config writes:
  - Take effect at the clk edge, regardless of stall.
  - A write and an S1 read of the same entry in the same cycle: the read returns the old value.
  - Beats accepted in later cycles see the new value.
- sat_clr and a new saturation in the same cycle: set wins.
- cfg_func values are never out of range, since N_FUNCS is a power of 2.

Decomposition:
- Shared package additions:
  - ACT_LANES, ACT_SEG_DEPTH, ACT_FUNC_SEL_W.
  - Reuse ACT_A_*/ACT_B_* coefficient widths.
  - Typedef act_coef_t, a packed struct {a, b}.
  - Typedef act_func_t.
- One natural sub-module: act_pwl_lane, covering S2/S3 arithmetic, round and saturate for one lane, instantiated LANES times.
- LUT array and handshake control stay in the top module.

Test Plan:
- Identity after reset: in_func=0, x = {0x1800, 0xE800, 0x0000, 0x7FFF} → same values, out_valid exactly 3 cycles after accept, sat_flag=0.
- Load bank 1, all segments A=0x2000, B=0x1000: x=0x1000 → 0x3000; x=0xF000 → 0xF000 (i.e. -1.0).
- Segment select: bank 2 with B = seg<<4 and A = 0; x = 0x8000, 0x0000, 0x7FFF → 0x0000, 0x0200, 0x03F0.
- Saturation: A=0x7FFF, B=0x7FFF; x=0x7FFF → 0x7FFF and sat_flag set; x=0x8000 with A=0x7FFF, B=0x8000 → 0x8000. Then sat_clr → flags return to 0.
- Backpressure: continuous in_valid, 20 beats with incrementing data, out_ready toggling randomly → all 20 outputs in order, correct; in_ready=0 exactly when out_valid && !out_ready.
- Write collision and reset: write an entry in the same cycle its S1 read occurs → old value used; assert rst_n=0 with 3 beats in flight → no outputs, LUT returns to identity.
